// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_arb_pkg
// Description : Shared types for the data-memory port arbiter: FSM state
//               encodings and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

   // Requester identifiers; the value doubles as the bit index in req[1:0]
   typedef enum logic {
      ID_CPU = 1'b0,
      ID_LDR = 1'b1
   } req_id_e;

endpackage : dm_arb_pkg
`default_nettype wire

// File: rtl/dm_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : dm_rr_pick
// Description : Two-way combinational round-robin pick between CPU (bit 0)
//               and loader (bit 1). With lock_i asserted while the loader
//               owned the last access, only the loader may win.
// Ports       : req_i[1:0]  request vector {LDR, CPU}
//               last_id_i   requester granted most recently
//               lock_i      loader bus lock (already gated by configuration)
//               win_id_o    selected requester
//               win_vld_o   a requester was selected
// Revision    : 1.0 - initial release
// ============================================================================
module dm_rr_pick
   import dm_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  req_id_e    last_id_i,
   input  logic       lock_i,
   output req_id_e    win_id_o,
   output logic       win_vld_o
);

   always_comb begin
      win_id_o  = ID_CPU;
      win_vld_o = 1'b0;
      if (lock_i && (last_id_i == ID_LDR)) begin
         // Burst load: the CPU is held off even when the loader is momentarily idle
         win_id_o  = ID_LDR;
         win_vld_o = req_i[1];
      end else if (req_i == 2'b11) begin
         win_id_o  = (last_id_i == ID_CPU) ? ID_LDR : ID_CPU;
         win_vld_o = 1'b1;
      end else if (req_i[0]) begin
         win_id_o  = ID_CPU;
         win_vld_o = 1'b1;
      end else if (req_i[1]) begin
         win_id_o  = ID_LDR;
         win_vld_o = 1'b1;
      end
   end

endmodule : dm_rr_pick
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_port_arbiter
// Description : Shares the single-port data memory between the CPU load/store
//               path and the program/data loader. One access at a time,
//               round-robin priority, registered memory strobes and grants,
//               read data routed back with a per-requester valid pulse.
// Ports       : clk/rst                   clock, synchronous active-high reset
//               cpu_* / ldr_*             requester handshakes (req/we/addr/
//                                         wdata in, gnt/rvalid out)
//               ldr_lock                  loader bus lock
//               rd_data                   shared read-return data
//               dm_addr/dm_wdata/dm_write/dm_read/dm_rdata  memory port
//               busy                      high whenever the FSM is not IDLE
// Config      : DM_ARB_LOCK_EN - when defined, ldr_lock holds the bus for the
//               loader; otherwise ldr_lock is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   input  logic              ldr_lock,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_write,
   output logic              dm_read,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              busy
);

   arb_state_e        state_q;
   req_id_e           last_id_q;
   req_id_e           win_id_q;
   logic              cpu_gnt_q, ldr_gnt_q;
   logic              cpu_rvalid_q, ldr_rvalid_q;
   logic              dm_write_q, dm_read_q;
   logic [ADDR_W-1:0] dm_addr_q;
   logic [DATA_W-1:0] dm_wdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              busy_q;

   logic              lock_d;
   req_id_e           win_id_d;
   logic              win_vld_d;
   logic              sel_we_d;
   logic [ADDR_W-1:0] sel_addr_d;
   logic [DATA_W-1:0] sel_wdata_d;

`ifdef DM_ARB_LOCK_EN
   assign lock_d = ldr_lock;
`else
   // Lock feature compiled out: the input is tied off inside the arbiter
   assign lock_d = ldr_lock & 1'b0;
`endif

   dm_rr_pick u_pick (
      .req_i     ({ldr_req, cpu_req}),
      .last_id_i (last_id_q),
      .lock_i    (lock_d),
      .win_id_o  (win_id_d),
      .win_vld_o (win_vld_d)
   );

   // Request fields of the selected requester
   assign sel_we_d    = (win_id_d == ID_LDR) ? ldr_we    : cpu_we;
   assign sel_addr_d  = (win_id_d == ID_LDR) ? ldr_addr  : cpu_addr;
   assign sel_wdata_d = (win_id_d == ID_LDR) ? ldr_wdata : cpu_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_id_q    <= ID_LDR;   // CPU wins the first tie
         win_id_q     <= ID_CPU;
         cpu_gnt_q    <= 1'b0;
         ldr_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         ldr_rvalid_q <= 1'b0;
         dm_write_q   <= 1'b0;
         dm_read_q    <= 1'b0;
         dm_addr_q    <= '0;
         dm_wdata_q   <= '0;
         rd_data_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         // Strobes, grants and valids are single-cycle pulses
         cpu_gnt_q    <= 1'b0;
         ldr_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         ldr_rvalid_q <= 1'b0;
         dm_write_q   <= 1'b0;
         dm_read_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_vld_d) begin
                  win_id_q   <= win_id_d;
                  dm_addr_q  <= sel_addr_d;
                  dm_wdata_q <= sel_wdata_d;
                  dm_write_q <= sel_we_d;
                  dm_read_q  <= ~sel_we_d;
                  cpu_gnt_q  <= (win_id_d == ID_CPU);
                  ldr_gnt_q  <= (win_id_d == ID_LDR);
                  busy_q     <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               last_id_q <= win_id_q;
               if (dm_write_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  // Memory returns data in the next cycle; flag it now
                  cpu_rvalid_q <= (win_id_q == ID_CPU);
                  ldr_rvalid_q <= (win_id_q == ID_LDR);
                  state_q      <= WAIT;
               end
            end
            WAIT: begin
               rd_data_q <= dm_rdata;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Memory data is forwarded during WAIT and held afterwards
   assign rd_data    = (state_q == WAIT) ? dm_rdata : rd_data_q;
   assign cpu_gnt    = cpu_gnt_q;
   assign ldr_gnt    = ldr_gnt_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign ldr_rvalid = ldr_rvalid_q;
   assign dm_addr    = dm_addr_q;
   assign dm_wdata   = dm_wdata_q;
   assign dm_write   = dm_write_q;
   assign dm_read    = dm_read_q;
   assign busy       = busy_q;

endmodule : dm_port_arbiter
`default_nettype wire
